// File: rtl/morse_letter_tx.sv
// rtl/morse_letter_tx.sv - Morse letter sender (A-Z) with unit timer, Busy/Done handshake and repeat loop
module morse_letter_tx #(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int TICKS_PER_UNIT  = CLOCK_FREQUENCY / 2,
    parameter int PATTERN_WIDTH   = 13,
    parameter int GAP_UNITS       = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Letter,
    input  logic       Repeat,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    localparam int TW = $clog2(TICKS_PER_UNIT) + 1;
    localparam int GW = $clog2(GAP_UNITS + 1) + 1;
    localparam logic [TW-1:0] UNIT_LOAD = TW'(TICKS_PER_UNIT - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_UNITS);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                   state, state_n;
    logic [PATTERN_WIDTH-1:0] shreg, shreg_n, pat_q, pat_n;
    logic [3:0]               len_q, len_n, len_rem, len_rem_n;
    logic [TW-1:0]            timer, timer_n;
    logic [GW-1:0]            gap_rem, gap_n;
    logic                     dd_n, nb_n, busy_n, done_n, err_n;

    logic [12:0]              lut_raw;
    logic [3:0]               lut_len;
    logic [PATTERN_WIDTH-1:0] lut_pattern;
    logic                     lut_valid;
    logic                     unit_end;

    // Right-justified dot/dash code; dot=1, dash=111, separated by single 0s
    always_comb begin
        {lut_len, lut_raw} = {4'd0, 13'b0};
        case (Letter)
            5'd0:  {lut_len, lut_raw} = {4'd5,  13'b10111};
            5'd1:  {lut_len, lut_raw} = {4'd9,  13'b111010101};
            5'd2:  {lut_len, lut_raw} = {4'd11, 13'b11101011101};
            5'd3:  {lut_len, lut_raw} = {4'd7,  13'b1110101};
            5'd4:  {lut_len, lut_raw} = {4'd1,  13'b1};
            5'd5:  {lut_len, lut_raw} = {4'd9,  13'b101011101};
            5'd6:  {lut_len, lut_raw} = {4'd9,  13'b111011101};
            5'd7:  {lut_len, lut_raw} = {4'd7,  13'b1010101};
            5'd8:  {lut_len, lut_raw} = {4'd3,  13'b101};
            5'd9:  {lut_len, lut_raw} = {4'd13, 13'b1011101110111};
            5'd10: {lut_len, lut_raw} = {4'd9,  13'b111010111};
            5'd11: {lut_len, lut_raw} = {4'd9,  13'b101110101};
            5'd12: {lut_len, lut_raw} = {4'd7,  13'b1110111};
            5'd13: {lut_len, lut_raw} = {4'd5,  13'b11101};
            5'd14: {lut_len, lut_raw} = {4'd11, 13'b11101110111};
            5'd15: {lut_len, lut_raw} = {4'd11, 13'b10111011101};
            5'd16: {lut_len, lut_raw} = {4'd13, 13'b1110111010111};
            5'd17: {lut_len, lut_raw} = {4'd7,  13'b1011101};
            5'd18: {lut_len, lut_raw} = {4'd5,  13'b10101};
            5'd19: {lut_len, lut_raw} = {4'd3,  13'b111};
            5'd20: {lut_len, lut_raw} = {4'd7,  13'b1010111};
            5'd21: {lut_len, lut_raw} = {4'd9,  13'b101010111};
            5'd22: {lut_len, lut_raw} = {4'd9,  13'b101110111};
            5'd23: {lut_len, lut_raw} = {4'd11, 13'b11101010111};
            5'd24: {lut_len, lut_raw} = {4'd13, 13'b1110101110111};
            5'd25: {lut_len, lut_raw} = {4'd11, 13'b11101110101};
            default: {lut_len, lut_raw} = {4'd0, 13'b0};
        endcase
        lut_valid   = (Letter < 5'd26);
        lut_pattern = PATTERN_WIDTH'(lut_raw) << (PATTERN_WIDTH - int'(lut_len));
    end

    assign unit_end = (timer == '0);

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        pat_n     = pat_q;
        len_n     = len_q;
        len_rem_n = len_rem;
        timer_n   = timer;
        gap_n     = gap_rem;
        nb_n      = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (lut_valid) begin
                        pat_n     = lut_pattern;
                        len_n     = lut_len;
                        shreg_n   = lut_pattern;
                        len_rem_n = lut_len;
                        timer_n   = UNIT_LOAD;
                        nb_n      = 1'b1;
                        state_n   = SEND;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!unit_end) begin
                    timer_n = timer - TW'(1);
                end else if (len_rem > 4'd1) begin
                    shreg_n   = shreg << 1;
                    len_rem_n = len_rem - 4'd1;
                    timer_n   = UNIT_LOAD;
                    nb_n      = 1'b1;
                end else if (Repeat) begin
                    timer_n = UNIT_LOAD;
                    nb_n    = 1'b1;
                    if (GAP_UNITS == 0) begin
                        shreg_n   = pat_q;
                        len_rem_n = len_q;
                    end else begin
                        gap_n   = GAP_LOAD;
                        state_n = GAP;
                    end
                end else begin
                    shreg_n   = '0;
                    len_rem_n = '0;
                    timer_n   = '0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end
            end
            GAP: begin
                if (!unit_end) begin
                    timer_n = timer - TW'(1);
                end else begin
                    timer_n = UNIT_LOAD;
                    nb_n    = 1'b1;
                    if (gap_rem <= GW'(1)) begin
                        shreg_n   = pat_q;
                        len_rem_n = len_q;
                        gap_n     = '0;
                        state_n   = SEND;
                    end else begin
                        gap_n = gap_rem - GW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Waveform is the pattern MSB only while sending; gaps and idle are dark
        dd_n   = (state_n == SEND) && shreg_n[PATTERN_WIDTH-1];
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state      <= IDLE;
            shreg      <= '0;
            pat_q      <= '0;
            len_q      <= '0;
            len_rem    <= '0;
            timer      <= '0;
            gap_rem    <= '0;
            DotDashOut <= 1'b0;
            NewBitOut  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            pat_q      <= pat_n;
            len_q      <= len_n;
            len_rem    <= len_rem_n;
            timer      <= timer_n;
            gap_rem    <= gap_n;
            DotDashOut <= dd_n;
            NewBitOut  <= nb_n;
            Busy       <= busy_n;
            Done       <= done_n;
            Err        <= err_n;
        end
    end

endmodule

// File: tb/tb_morse_letter_tx.sv
// tb/tb_morse_letter_tx.sv - scoreboard bench for morse_letter_tx against a dot/dash string model
module tb_morse_letter_tx;

    localparam int T = 4;
    localparam int G = 3;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [4:0] Letter = 5'd0;
    logic       Repeat = 1'b0;
    logic       DotDashOut, NewBitOut, Busy, Done, Err;

    int errors = 0;
    int checks = 0;

    // Tuple layout: {DotDashOut, NewBitOut, Busy, Done, Err}
    logic [4:0] exp_q[$];

    string morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    morse_letter_tx #(
        .CLOCK_FREQUENCY(8),
        .TICKS_PER_UNIT (T),
        .PATTERN_WIDTH  (13),
        .GAP_UNITS      (G)
    ) dut (
        .ClockIn   (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Letter    (Letter),
        .Repeat    (Repeat),
        .DotDashOut(DotDashOut),
        .NewBitOut (NewBitOut),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    task automatic push_unit(input logic v);
        for (int t = 0; t < T; t++)
            exp_q.push_back({v, (t == 0), 1'b1, 1'b0, 1'b0});
    endtask

    task automatic push_letter(input int l);
        string s;
        byte   ch;
        s = morse[l];
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (i > 0) push_unit(1'b0);
            repeat ((ch == 8'd45) ? 3 : 1) push_unit(1'b1);
        end
    endtask

    // Called at a negedge; returns at the negedge of the Done cycle, or of the
    // cycle in which Reset was raised when stop_at > 0.
    task automatic send(input int l, input int copies, input int stop_at);
        int base, copy_cyc, busy_cyc, drop, limit;
        base = exp_q.size();
        push_letter(l);
        copy_cyc = exp_q.size() - base;
        for (int c = 1; c < copies; c++) begin
            repeat (G) push_unit(1'b0);
            push_letter(l);
        end
        busy_cyc = exp_q.size() - base;
        if (stop_at > 0) begin
            while (exp_q.size() > base + stop_at) void'(exp_q.pop_back());
        end else begin
            exp_q.push_back(5'b00010);
        end
        drop   = (copies - 1) * (copy_cyc + G * T) + 1 + int'($urandom_range(0, copy_cyc - 1));
        Letter = 5'(l);
        Start  = 1'b1;
        Repeat = (copies > 1);
        limit  = (stop_at > 0) ? stop_at : busy_cyc;
        for (int j = 1; j <= limit; j++) begin
            @(negedge clk);
            Start  = 1'($urandom_range(0, 1));
            Letter = 5'($urandom_range(0, 31));
            if (j == drop) Repeat = 1'b0;
        end
        if (stop_at > 0) begin
            Reset = 1'b1;
        end else begin
            @(negedge clk);
        end
        Start  = 1'b0;
        Repeat = 1'b0;
    endtask

    task automatic send_bad(input int l);
        exp_q.push_back(5'b00001);
        Letter = 5'(l);
        Start  = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({DotDashOut, NewBitOut, Busy, Done, Err} !== 5'b0) begin
            errors++;
            $display("FAIL %s got=%b expected=00000", name,
                     {DotDashOut, NewBitOut, Busy, Done, Err});
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] act, e;
        act = {DotDashOut, NewBitOut, Busy, Done, Err};
        if (act != 5'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output at %0t got=%b expected=none", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL output_tuple at %0t got=%b expected=%b", $time, act, e);
                end
            end
        end
    end

    initial begin
        int l, copies;
        repeat (2) @(negedge clk);
        check_idle("reset_state");
        Reset = 1'b0;
        @(negedge clk);
        check_idle("idle_after_reset");

        send(0, 1, 0);
        @(negedge clk);
        send(4, 1, 0);
        @(negedge clk);
        send(9, 3, 0);
        @(negedge clk);
        send_bad(27);
        @(negedge clk);
        check_idle("err_no_busy");

        send(0, 1, 10);
        @(negedge clk);
        check_idle("after_mid_unit_reset");
        Reset = 1'b0;
        send(0, 1, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            l = int'($urandom_range(0, 31));
            if (l > 25) begin
                send_bad(l);
            end else begin
                copies = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 3)) : 1;
                send(l, copies, 0);
            end
        end
        Start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
